// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Synthesizable stand-in for a 4x4 hex keypad, sitting on the far side of the matrix from the
//   scanner. A "press key K" request is taken over a valid/ready handshake. The key's row/column
//   crossing is then closed with a deterministic bounce / hold / bounce / gap envelope.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   press_valid  request to press press_key
//   press_key    hex value of the key to press
//   press_ready  high when a request can be accepted
//   press_done   one-cycle pulse when a press/release sequence completes
//   key_active   high from acceptance until press_done
//   row          one-hot active-high row drive from the scanner
//   col          one-hot active-high column sense back to the scanner (combinational from row)

module keypad_emulator #(
    parameter int unsigned BOUNCE_CYCLES = 8,
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned GAP_CYCLES    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       press_valid,
    input  logic [3:0] press_key,
    output logic       press_ready,
    output logic       press_done,
    output logic       key_active,
    input  logic [3:0] row,
    output logic [3:0] col
);

    localparam int unsigned MAX_BH     = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES
                                                                       : HOLD_CYCLES;
    localparam int unsigned MAX_CYCLES = (MAX_BH > GAP_CYCLES) ? MAX_BH : GAP_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    // Last counter value of each timed state; the bounce value is unused when bounce is disabled.
    localparam logic [CW-1:0] BOUNCE_LAST = CW'(BOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StBouncePress,
        StHold,
        StBounceRelease,
        StGap
    } state_e;

    state_e        state;
    logic [CW-1:0] cnt;
    logic [1:0]    key_row;
    logic [3:0]    key_col;
    logic          contact;

    // Key map: returns {row index, column one-hot}.
    function automatic logic [5:0] encode_key(input logic [3:0] k);
        logic [5:0] e;
        case (k)
            4'h1:    e = {2'd3, 4'b0001};
            4'h2:    e = {2'd3, 4'b0010};
            4'h3:    e = {2'd3, 4'b0100};
            4'hA:    e = {2'd3, 4'b1000};
            4'h4:    e = {2'd2, 4'b0001};
            4'h5:    e = {2'd2, 4'b0010};
            4'h6:    e = {2'd2, 4'b0100};
            4'hB:    e = {2'd2, 4'b1000};
            4'h7:    e = {2'd1, 4'b0001};
            4'h8:    e = {2'd1, 4'b0010};
            4'h9:    e = {2'd1, 4'b0100};
            4'hC:    e = {2'd1, 4'b1000};
            4'hE:    e = {2'd0, 4'b0001};
            4'h0:    e = {2'd0, 4'b0010};
            4'hF:    e = {2'd0, 4'b0100};
            default: e = {2'd0, 4'b1000}; // 4'hD
        endcase
        return e;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            cnt         <= '0;
            key_row     <= 2'd0;
            key_col     <= 4'b0000;
            press_ready <= 1'b0;
            press_done  <= 1'b0;
        end else begin
            press_done <= 1'b0;
            cnt        <= cnt + CW'(1);
            case (state)
                StIdle: begin
                    cnt         <= '0;
                    press_ready <= 1'b1;
                    if (press_valid && press_ready) begin
                        {key_row, key_col} <= encode_key(press_key);
                        press_ready        <= 1'b0;
                        state              <= (BOUNCE_CYCLES == 0) ? StHold : StBouncePress;
                    end
                end
                StBouncePress: begin
                    if (cnt == BOUNCE_LAST) begin
                        cnt   <= '0;
                        state <= StHold;
                    end
                end
                StHold: begin
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= (BOUNCE_CYCLES == 0) ? StGap : StBounceRelease;
                    end
                end
                StBounceRelease: begin
                    if (cnt == BOUNCE_LAST) begin
                        cnt   <= '0;
                        state <= StGap;
                    end
                end
                StGap: begin
                    if (cnt == GAP_LAST) begin
                        cnt         <= '0;
                        state       <= StIdle;
                        press_done  <= 1'b1;
                        // Ready in the done cycle so a back-to-back request can be taken there.
                        press_ready <= 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= StIdle;
                end
            endcase
        end
    end

    // Press bounce starts closed (1,0,1,0...), release bounce starts open (0,1,0,1...).
    always_comb begin
        contact = 1'b0;
        case (state)
            StBouncePress:   contact = ~cnt[0];
            StHold:          contact = 1'b1;
            StBounceRelease: contact = cnt[0];
            default:         contact = 1'b0;
        endcase
    end

    assign key_active = (state != StIdle);

    // Only the key's own row bit matters; other row bits are ignored.
    assign col = (contact && row[key_row]) ? key_col : 4'b0000;

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

    localparam int AB = 4;
    localparam int AH = 10;
    localparam int AG = 2;
    localparam int A_TOTAL = 2 * AB + AH + AG;
    localparam int BB = 0;
    localparam int BH = 1;
    localparam int BG = 1;
    localparam int B_TOTAL = 2 * BB + BH + BG;

    // Keypad face, top row (row[3]) first, columns c0..c3 left to right.
    localparam logic [63:0] LAYOUT = 64'h123A_456B_789C_E0FD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, a_valid, a_ready, a_done, a_active;
    logic [3:0] a_key, a_row, a_col;
    logic       b_reset, b_valid, b_ready, b_done, b_active;
    logic [3:0] b_key, b_row, b_col;

    int n_checks = 0;
    int n_pass   = 0;

    keypad_emulator #(
        .BOUNCE_CYCLES(AB),
        .HOLD_CYCLES  (AH),
        .GAP_CYCLES   (AG)
    ) dut_a (
        .clk        (clk),
        .reset      (a_reset),
        .press_valid(a_valid),
        .press_key  (a_key),
        .press_ready(a_ready),
        .press_done (a_done),
        .key_active (a_active),
        .row        (a_row),
        .col        (a_col)
    );

    keypad_emulator #(
        .BOUNCE_CYCLES(BB),
        .HOLD_CYCLES  (BH),
        .GAP_CYCLES   (BG)
    ) dut_b (
        .clk        (clk),
        .reset      (b_reset),
        .press_valid(b_valid),
        .press_key  (b_key),
        .press_ready(b_ready),
        .press_done (b_done),
        .key_active (b_active),
        .row        (b_row),
        .col        (b_col)
    );

    // Contact state t cycles after the acceptance edge.
    function automatic logic model_contact(input int t, input int b, input int h);
        if (t >= 1 && t <= b)             return ((t - 1) % 2) == 0;
        if (t > b && t <= b + h)          return 1'b1;
        if (t > b + h && t <= 2 * b + h)  return ((t - b - h - 1) % 2) == 1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_col(input logic [3:0] key, input logic [3:0] r,
                                             input int t, input int b, input int h);
        logic [63:0] lay;
        int kr;
        int kc;
        lay = LAYOUT;
        kr  = 0;
        kc  = 0;
        for (int i = 0; i < 16; i++) begin
            if (lay[63-4*i -: 4] == key) begin
                kr = 3 - i / 4;
                kc = i % 4;
            end
        end
        if (model_contact(t, b, h) && r[kr]) return 4'(1 << kc);
        return 4'b0000;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Waits for ready, presents one request; returns in cycle k+1 (k = acceptance edge).
    task automatic press_a(input logic [3:0] key);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!a_ready && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (!a_ready) begin
            n_checks++;
            $display("FAIL press_a_wait_ready: ready=%b required 1", a_ready);
        end
        a_key   = key;
        a_valid = 1'b1;
        next_cycle();
        a_valid = 1'b0;
    endtask

    task automatic press_b(input logic [3:0] key);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!b_ready && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (!b_ready) begin
            n_checks++;
            $display("FAIL press_b_wait_ready: ready=%b required 1", b_ready);
        end
        b_key   = key;
        b_valid = 1'b1;
        next_cycle();
        b_valid = 1'b0;
    endtask

    // Runs the current sequence on dut_a out to its done cycle and one cycle beyond.
    task automatic drain_a();
        int waited;
        waited = 0;
        @(negedge clk);
        while (!a_done && waited < 5000) begin
            @(negedge clk);
            waited++;
        end
        if (!a_done) begin
            n_checks++;
            $display("FAIL drain_a_wait_done: done=%b required 1", a_done);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        a_reset = 1'b1;
        b_reset = 1'b1;
        a_row   = 4'hF;
        b_row   = 4'hF;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({a_ready, a_done, a_active, a_col} !== 7'b0)
            $display("FAIL reset_a_outputs: ready/done/active/col=%b required 0000000",
                     {a_ready, a_done, a_active, a_col});
        else n_pass++;
        n_checks++;
        if ({b_ready, b_done, b_active, b_col} !== 7'b0)
            $display("FAIL reset_b_outputs: ready/done/active/col=%b required 0000000",
                     {b_ready, b_done, b_active, b_col});
        else n_pass++;
        next_cycle();
        a_reset = 1'b0;
        b_reset = 1'b0;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1)
            $display("FAIL reset_release_ready: a=%b b=%b required 1 1", a_ready, b_ready);
        else n_pass++;
        n_checks++;
        if (a_done !== 1'b0 || a_active !== 1'b0 || a_col !== 4'b0)
            $display("FAIL reset_release_idle: done=%b active=%b col=%b required 0 0 0000",
                     a_done, a_active, a_col);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_key5_envelope();
        logic [3:0] exp;
        press_a(4'h5);
        for (int t = 1; t <= A_TOTAL + 2; t++) begin
            a_row = 4'b0100;
            @(negedge clk);
            exp = model_col(4'h5, a_row, t, AB, AH);
            n_checks++;
            if (a_col !== exp) $display("FAIL key5_col t=%0d: col=%b required %b", t, a_col, exp);
            else n_pass++;
            n_checks++;
            if (a_active !== (t <= A_TOTAL))
                $display("FAIL key5_active t=%0d: active=%b required %b", t, a_active,
                         (t <= A_TOTAL));
            else n_pass++;
            n_checks++;
            if (a_done !== (t == A_TOTAL + 1))
                $display("FAIL key5_done t=%0d: done=%b required %b", t, a_done,
                         (t == A_TOTAL + 1));
            else n_pass++;
            n_checks++;
            if (a_ready !== (t >= A_TOTAL + 1))
                $display("FAIL key5_ready t=%0d: ready=%b required %b", t, a_ready,
                         (t >= A_TOTAL + 1));
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_sweep_keys();
        logic [3:0] exp;
        for (int k = 0; k < 16; k++) begin
            a_row = 4'b0000;
            press_a(4'(k));
            for (int t = 1; t <= AB; t++) next_cycle();
            for (int r = 0; r < 4; r++) begin
                a_row = 4'(1 << r);
                @(negedge clk);
                exp = model_col(4'(k), a_row, AB + 1 + r, AB, AH);
                n_checks++;
                if (a_col !== exp)
                    $display("FAIL sweep_col key=%h row=%b: col=%b required %b", k, a_row,
                             a_col, exp);
                else n_pass++;
                next_cycle();
            end
            a_row = 4'b0000;
            for (int t = AB + 5; t <= A_TOTAL; t++) next_cycle();
            @(negedge clk);
            n_checks++;
            if (a_done !== 1'b1)
                $display("FAIL sweep_done key=%h: done=%b required 1", k, a_done);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_ignore_during_hold();
        logic [3:0] exp;
        press_a(4'h9);
        for (int t = 1; t <= A_TOTAL + 1; t++) begin
            if (t == AB + 1) begin
                a_valid = 1'b1;
                a_key   = 4'h3;
            end
            a_row = 4'($urandom_range(0, 15));
            @(negedge clk);
            exp = model_col(4'h9, a_row, t, AB, AH);
            n_checks++;
            if (a_col !== exp)
                $display("FAIL ignore_col t=%0d row=%b: col=%b required %b", t, a_row, a_col, exp);
            else n_pass++;
            if (t == A_TOTAL + 1) begin
                n_checks++;
                if (a_done !== 1'b1 || a_ready !== 1'b1)
                    $display("FAIL ignore_done_cycle: done=%b ready=%b required 1 1",
                             a_done, a_ready);
                else n_pass++;
            end
            next_cycle();
        end
        // The held key-3 request is taken at the done-cycle edge.
        a_valid = 1'b0;
        a_row   = 4'b1000;
        @(negedge clk);
        n_checks++;
        if (a_active !== 1'b1 || a_col !== 4'b0100 || a_done !== 1'b0)
            $display("FAIL back_to_back_accept: active=%b col=%b done=%b required 1 0100 0",
                     a_active, a_col, a_done);
        else n_pass++;
        a_row = 4'b0010;
        #1;
        n_checks++;
        if (a_col !== 4'b0000)
            $display("FAIL back_to_back_other_row: col=%b required 0000", a_col);
        else n_pass++;
        drain_a();
    endtask

    task automatic test_reset_mid_hold();
        int done_seen;
        done_seen = 0;
        a_row = 4'hF;
        press_a(4'($urandom_range(0, 15)));
        for (int t = 1; t < AB + 5; t++) next_cycle();
        a_reset = 1'b1;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({a_col, a_active, a_done, a_ready} !== 7'b0)
            $display("FAIL mid_reset_outputs: col/active/done/ready=%b required 0000000",
                     {a_col, a_active, a_done, a_ready});
        else n_pass++;
        next_cycle();
        a_reset = 1'b0;
        for (int t = 0; t < A_TOTAL; t++) begin
            next_cycle();
            @(negedge clk);
            if (a_done) done_seen++;
            if (t == 0) begin
                n_checks++;
                if (a_ready !== 1'b1 || a_active !== 1'b0 || a_col !== 4'b0)
                    $display("FAIL mid_reset_recover: ready=%b active=%b col=%b required 1 0 0000",
                             a_ready, a_active, a_col);
                else n_pass++;
            end
        end
        n_checks++;
        if (done_seen != 0)
            $display("FAIL mid_reset_no_done: done pulses=%0d required 0", done_seen);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_no_bounce();
        logic [3:0] exp;
        int         hits;
        hits  = 0;
        b_row = 4'b0001;
        press_b(4'hF);
        for (int t = 1; t <= B_TOTAL + 2; t++) begin
            @(negedge clk);
            exp = model_col(4'hF, b_row, t, BB, BH);
            if (b_col == 4'b0100) hits++;
            n_checks++;
            if (b_col !== exp) $display("FAIL nobounce_col t=%0d: col=%b required %b", t, b_col, exp);
            else n_pass++;
            n_checks++;
            if (b_done !== (t == B_TOTAL + 1))
                $display("FAIL nobounce_done t=%0d: done=%b required %b", t, b_done,
                         (t == B_TOTAL + 1));
            else n_pass++;
            next_cycle();
        end
        n_checks++;
        if (hits != 1) $display("FAIL nobounce_contact_cycles: got %0d required 1", hits);
        else n_pass++;
    endtask

    task automatic test_multi_row();
        a_row = 4'b0000;
        press_a(4'h7);
        for (int t = 1; t <= AB; t++) next_cycle();
        a_row = 4'b1111;
        @(negedge clk);
        n_checks++;
        if (a_col !== 4'b0001) $display("FAIL multirow_1111: col=%b required 0001", a_col);
        else n_pass++;
        next_cycle();
        a_row = 4'b1101;
        @(negedge clk);
        n_checks++;
        if (a_col !== 4'b0000) $display("FAIL multirow_1101: col=%b required 0000", a_col);
        else n_pass++;
        drain_a();
    endtask

    task automatic test_random();
        logic [3:0] key;
        logic [3:0] exp;
        for (int n = 0; n < 25; n++) begin
            key = 4'($urandom_range(0, 15));
            for (int g = $urandom_range(0, 3); g > 0; g--) next_cycle();
            press_a(key);
            for (int t = 1; t <= A_TOTAL + 1; t++) begin
                a_row = 4'($urandom_range(0, 15));
                @(negedge clk);
                exp = model_col(key, a_row, t, AB, AH);
                n_checks++;
                if (a_col !== exp)
                    $display("FAIL random_col key=%h t=%0d row=%b: col=%b required %b",
                             key, t, a_row, a_col, exp);
                else n_pass++;
                n_checks++;
                if (a_done !== (t == A_TOTAL + 1) || a_active !== (t <= A_TOTAL))
                    $display("FAIL random_ctrl key=%h t=%0d: done=%b active=%b", key, t,
                             a_done, a_active);
                else n_pass++;
                next_cycle();
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_reset = 1'b1;
        a_valid = 1'b0;
        a_key   = 4'h0;
        a_row   = 4'h0;
        b_reset = 1'b1;
        b_valid = 1'b0;
        b_key   = 4'h0;
        b_row   = 4'h0;
        test_reset();
        test_key5_envelope();
        test_sweep_keys();
        test_ignore_during_hold();
        test_reset_mid_hold();
        test_no_bounce();
        test_multi_row();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

- Synthesizable stand-in for the 4x4 hex keypad, on the opposite end of the matrix from the scanner.
- Accepts a "press key K" request over a valid/ready handshake and encodes K into its row/column crossing.
- Senses the row currently being driven and returns the matching column, with a timed, deterministic contact-bounce/hold/release envelope.
- Used in hardware-in-loop and bench setups to exercise the scanner, debouncer and key decoding without a physical keypad.

## Interface
Parameters:
- BOUNCE_CYCLES, 8: cycles of bounce on press and on release; 0 disables bounce.
- HOLD_CYCLES, 1000: cycles of solid contact; must be >= 1.
- GAP_CYCLES, 16: cycles of open contact after release before the next request is accepted; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- press_valid  in  1  request to press press_key.
- press_key  in  4  hex value of the key to press.
- press_ready  out  1  high when a request can be accepted.
- press_done  out  1  one-cycle pulse when a press/release sequence completes.
- key_active  out  1  high from acceptance until press_done.
- row  in  4  one-hot active-high row drive from the scanner.
- col  out  4  one-hot active-high column sense returned to the scanner.

## Operation
- Key map, given as row bit / col bit:
  - row[3]: 1/c0, 2/c1, 3/c2, A/c3
  - row[2]: 4/c0, 5/c1, 6/c2, B/c3
  - row[1]: 7/c0, 8/c1, 9/c2, C/c3
  - row[0]: E/c0, 0/c1, F/c2, D/c3
- On acceptance, register the encoded key_row index (2 bits) and key_col one-hot.
- Combinational return path: col = (contact && row[key_row]) ? key_col : 4'b0000.
  - Other row bits are ignored, so a non-one-hot row still answers only on the key's row bit.
  - No contact gives col = 0.
- States: IDLE, BOUNCE_PRESS, HOLD, BOUNCE_RELEASE, GAP.
  - IDLE: press_ready = 1, contact = 0. When press_valid && press_ready, latch the key and go to BOUNCE_PRESS, or to HOLD if BOUNCE_CYCLES == 0.
  - BOUNCE_PRESS: counter n = 0..BOUNCE_CYCLES-1. contact = ~n[0], giving the pattern 1,0,1,0... Then go to HOLD.
  - HOLD: HOLD_CYCLES cycles with contact = 1. Then go to BOUNCE_RELEASE, or to GAP if BOUNCE_CYCLES == 0.
  - BOUNCE_RELEASE: n = 0..BOUNCE_CYCLES-1. contact = n[0], giving the pattern 0,1,0,1... Then go to GAP.
  - GAP: GAP_CYCLES cycles with contact = 0. Then go to IDLE and assert press_done for that first IDLE cycle.
- One shared counter, width $clog2(max(BOUNCE_CYCLES, HOLD_CYCLES, GAP_CYCLES) + 1). It clears on every state change.
- press_valid outside IDLE is ignored; nothing is queued. press_key is sampled only at acceptance.
- key_active = (state != IDLE).

## Timing
- Reset values:
  - State IDLE, counter 0, key_row 0, key_col 0.
  - press_ready = 0 while reset is high; it rises in the first cycle after reset falls.
  - press_done = 0, key_active = 0, col = 0.
- Reset mid-sequence: at the next edge the state returns to IDLE and contact drops, so col = 0. No press_done is issued for the aborted press.
- Acceptance edge k:
  - key_active = 1 from cycle k+1.
  - First bounce contact (col valid for a matching row) in cycle k+1.
- Solid contact spans cycles k+1+BOUNCE_CYCLES through k+BOUNCE_CYCLES+HOLD_CYCLES.
- press_done and press_ready are both high in cycle k+1+2*BOUNCE_CYCLES+HOLD_CYCLES+GAP_CYCLES. A new request can be accepted in that same cycle; press_done still pulses once.
- col has zero latency from row within a cycle.

## Test plan
- Key 5, BOUNCE_CYCLES = 4, HOLD_CYCLES = 10, GAP_CYCLES = 2, row = 0100 held:
  - col = 0010 on bounce cycles with pattern 1,0,1,0, then 10 cycles of 0010, then pattern 0,1,0,1, then 2 cycles of 0000.
  - press_done in cycle k+21.
- Sweep all 16 keys while cycling row one-hot, sampling during HOLD. Required returns:
  - 0 → row[0]/0010
  - A → row[3]/1000
  - E → row[0]/0001
  - D → row[0]/1000
  - col = 0 for non-matching rows.
- press_valid held high with key 3 during HOLD of key 9: the second request is ignored; col stays 0100 on row[1] only. The key-3 request is accepted in the press_done cycle.
- Assert reset in HOLD cycle 5: col = 0, key_active = 0, no press_done, press_ready = 1 one cycle after reset falls.
- BOUNCE_CYCLES = 0, HOLD_CYCLES = 1, GAP_CYCLES = 1, key F: exactly one cycle of col = 0100 with row = 0001, and press_done at k+3.
- Key 7 with row = 1111: col = 0001. With row = 1101: col = 0000.
